counter_ctrl_arbiter: RTL and testbench

Wishbone-mapped control and arbitration block for the user-area counter datapath.
- Holds CTRL/LOAD/LIMIT/STATUS registers and sequences the counter through a run/halt FSM.
- Arbitrates counter load requests between the Wishbone host and the logic-analyzer port (round-robin).
- Sits between the user project wrapper's Wishbone/LA signals and the counter core; raises a user IRQ on limit hit.

---
 rtl/ctrl_arb_pkg.sv | 36 +++
 rtl/rr_arbiter2.sv | 38 +++
 rtl/counter_ctrl_arbiter.sv | 151 +++++++++++++++
 tb/tb_counter_ctrl_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_arb_pkg.sv
// Shared types and constants for the counter control/arbitration block.
package ctrl_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_LOAD   = 2'd1;
  localparam logic [1:0] REG_LIMIT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_ONESHOT  = 1;
  localparam int CTRL_IRQ_EN   = 3;
  localparam int CTRL_STEP_LSB = 8;
  localparam logic [31:0] CTRL_MASK = 32'h0000_FF0B;

  localparam int STAT_RUN  = 0;
  localparam int STAT_HIT  = 1;
  localparam int STAT_PEND = 2;

  localparam logic REQ_WB = 1'b0;
  localparam logic REQ_LA = 1'b1;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  sel);
    logic [31:0] m;
    m = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    return (old_val & ~m) | (new_val & m);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter: combinational grant, registered last-grant.
// Requests are levels; a loser is served the next cycle if it still requests.
module rr_arbiter2
  import ctrl_arb_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_req_wb,
  input  logic i_req_la,
  output logic o_gnt_vld,
  output logic o_gnt_id
);

  logic r_last;

  always_comb begin
    o_gnt_vld = 1'b0;
    o_gnt_id  = REQ_WB;
    if (!i_rst) begin
      if (i_req_wb && i_req_la) begin
        o_gnt_vld = 1'b1;
        o_gnt_id  = (r_last == REQ_LA) ? REQ_WB : REQ_LA;
      end else if (i_req_wb) begin
        o_gnt_vld = 1'b1;
        o_gnt_id  = REQ_WB;
      end else if (i_req_la) begin
        o_gnt_vld = 1'b1;
        o_gnt_id  = REQ_LA;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)          r_last <= REQ_LA;
    else if (o_gnt_vld) r_last <= o_gnt_id;
  end

endmodule

// File: rtl/counter_ctrl_arbiter.sv
// Wishbone register block, run/halt FSM and WB/LA load arbitration for the counter.
// Ack one cycle after the access edge, never back-to-back; loads issue the cycle after request.
module counter_ctrl_arbiter
  import ctrl_arb_pkg::*;
#(
  parameter int          BITS      = 30,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_dat_i,
  input  logic [31:0]     wbs_adr_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  input  logic            la_load_req,
  input  logic [BITS-1:0] la_load_val,
  output logic            la_load_gnt,
  input  logic [BITS-1:0] cnt_value,
  output logic            cnt_load,
  output logic [BITS-1:0] cnt_load_val,
  output logic            cnt_en,
  output logic [7:0]      cnt_step,
  output logic            irq
);

  logic            r_ack;
  logic [31:0]     r_dat;
  logic [31:0]     r_ctrl;
  logic [BITS-1:0] r_load;
  logic [BITS-1:0] r_limit;
  logic            r_hit;
  logic            r_wb_pend;
  state_t          r_state;

  state_t          w_state_nxt;
  logic            w_hit_set;
  logic            w_acc;
  logic            w_addr_hit;
  logic            w_wr;
  logic [1:0]      w_reg;
  logic            w_load_wr;
  logic            w_w1c;
  logic            w_gnt_vld;
  logic            w_gnt_id;
  logic [31:0]     w_cnt32;
  logic [31:0]     w_status;
  logic            w_unused;

  assign w_acc      = wbs_cyc_i & wbs_stb_i & ~r_ack;
  assign w_addr_hit = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign w_reg      = wbs_adr_i[3:2];
  assign w_wr       = w_acc & wbs_we_i & w_addr_hit;
  assign w_load_wr  = w_wr & (w_reg == REG_LOAD);
  assign w_w1c      = w_wr & (w_reg == REG_STATUS) & wbs_sel_i[0] & wbs_dat_i[STAT_HIT];
  assign w_cnt32    = 32'(cnt_value);
  assign w_unused   = &{1'b0, wbs_adr_i[1:0], w_cnt32[31:24]};

  rr_arbiter2 u_arb (
    .i_clk     (wb_clk_i),
    .i_rst     (wb_rst_i),
    .i_req_wb  (r_wb_pend),
    .i_req_la  (la_load_req),
    .o_gnt_vld (w_gnt_vld),
    .o_gnt_id  (w_gnt_id)
  );

  always_comb begin
    w_status            = '0;
    w_status[STAT_RUN]  = (r_state == ST_RUN);
    w_status[STAT_HIT]  = r_hit;
    w_status[STAT_PEND] = r_wb_pend;
    w_status[31:8]      = w_cnt32[23:0];
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hit_set   = 1'b0;
    case (r_state)
      ST_IDLE: if (r_ctrl[CTRL_EN]) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (!r_ctrl[CTRL_EN]) begin
          w_state_nxt = ST_IDLE;
        end else if (r_ctrl[CTRL_ONESHOT]) begin
          if (cnt_value >= r_limit) begin
            w_state_nxt = ST_HALT;
            w_hit_set   = 1'b1;
          end
        end else if (cnt_value == r_limit) begin
          w_hit_set = 1'b1;
        end
      end
      ST_HALT: begin
        if (!r_ctrl[CTRL_EN]) w_state_nxt = ST_IDLE;
        else if (w_gnt_vld)   w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack     <= 1'b0;
      r_dat     <= '0;
      r_ctrl    <= '0;
      r_load    <= '0;
      r_limit   <= '0;
      r_hit     <= 1'b0;
      r_wb_pend <= 1'b0;
      r_state   <= ST_IDLE;
    end else begin
      r_ack   <= w_acc;
      r_dat   <= '0;
      r_state <= w_state_nxt;
      if (w_acc && !wbs_we_i && w_addr_hit) begin
        case (w_reg)
          REG_CTRL:  r_dat <= r_ctrl;
          REG_LOAD:  r_dat <= 32'(r_load);
          REG_LIMIT: r_dat <= 32'(r_limit);
          default:   r_dat <= w_status;
        endcase
      end
      if (w_wr && w_reg == REG_CTRL)
        r_ctrl <= byte_merge(r_ctrl, wbs_dat_i, wbs_sel_i) & CTRL_MASK;
      if (w_load_wr)
        r_load <= BITS'(byte_merge(32'(r_load), wbs_dat_i, wbs_sel_i));
      if (w_wr && w_reg == REG_LIMIT)
        r_limit <= BITS'(byte_merge(32'(r_limit), wbs_dat_i, wbs_sel_i));
      // A fresh LOAD write outranks a WB grant in the same cycle.
      if (w_load_wr)
        r_wb_pend <= 1'b1;
      else if (w_gnt_vld && w_gnt_id == REQ_WB)
        r_wb_pend <= 1'b0;
      if (w_hit_set)  r_hit <= 1'b1;
      else if (w_w1c) r_hit <= 1'b0;
    end
  end

  assign wbs_ack_o    = r_ack;
  assign wbs_dat_o    = r_dat;
  assign cnt_load     = w_gnt_vld;
  assign la_load_gnt  = w_gnt_vld & (w_gnt_id == REQ_LA);
  assign cnt_load_val = !w_gnt_vld ? '0 : (w_gnt_id == REQ_LA) ? la_load_val : r_load;
  assign cnt_en       = (r_state == ST_RUN) & ~w_gnt_vld;
  assign cnt_step     = r_ctrl[CTRL_STEP_LSB +: 8];
  assign irq          = r_hit & r_ctrl[CTRL_IRQ_EN];

endmodule

// File: tb/tb_counter_ctrl_arbiter.sv
// Scoreboard bench for counter_ctrl_arbiter: expected acks and loads are queued by stimulus,
// a negedge monitor pops and compares whenever the DUT acks or loads.
module tb_counter_ctrl_arbiter;

  localparam int BITS = 30;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] A_CTRL = BASE + 32'h0, A_LOAD = BASE + 32'h4;
  localparam logic [31:0] A_LIMIT = BASE + 32'h8, A_STAT = BASE + 32'hC;

  logic            clk = 1'b0;
  logic            rst;
  logic            stb, cyc, we;
  logic [3:0]      sel;
  logic [31:0]     dat_i, adr;
  logic            ack;
  logic [31:0]     dat_o;
  logic            la_req;
  logic [BITS-1:0] la_val;
  logic            la_gnt;
  logic [BITS-1:0] cnt_value;
  logic            cnt_load;
  logic [BITS-1:0] cnt_load_val;
  logic            cnt_en;
  logic [7:0]      cnt_step;
  logic            irq;

  typedef struct packed { logic we; logic [31:0] dat; } acc_t;
  typedef struct packed { logic la; logic [BITS-1:0] val; } ld_t;

  acc_t exp_acc[$];
  ld_t  exp_ld[$];
  int   n_chk = 0;
  int   n_err = 0;

  counter_ctrl_arbiter #(.BITS(BITS), .BASE_ADDR(BASE)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_dat_i(dat_i), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .la_load_req(la_req), .la_load_val(la_val), .la_load_gnt(la_gnt),
    .cnt_value(cnt_value), .cnt_load(cnt_load), .cnt_load_val(cnt_load_val),
    .cnt_en(cnt_en), .cnt_step(cnt_step), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ld(input logic la, input logic [BITS-1:0] val);
    ld_t l;
    l.la  = la;
    l.val = val;
    exp_ld.push_back(l);
  endtask

  // One Wishbone access; optionally raises the LA request right after the access edge.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [31:0] rd_exp, input logic la_after);
    acc_t e;
    e.we  = w;
    e.dat = rd_exp;
    exp_acc.push_back(e);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
    tick();
    if (la_after) la_req = 1'b1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    chk("ack_latency", 32'(ack), 1);
    tick();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    xfer(1'b1, a, d, 4'hF, 0, 1'b0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp);
    xfer(1'b0, a, 0, 4'hF, exp, 1'b0);
  endtask

  // Monitor: compares every ack and every load strobe against the queued expectations.
  initial begin
    acc_t a;
    ld_t  l;
    forever begin
      @(negedge clk);
      if (ack) begin
        if (exp_acc.size() == 0) chk("ack_unexpected", 32'(ack), 0);
        else begin
          a = exp_acc.pop_front();
          if (!a.we) chk("rd_data", dat_o, a.dat);
        end
      end
      if (cnt_load) begin
        if (exp_ld.size() == 0) chk("load_unexpected", 32'(cnt_load), 0);
        else begin
          l = exp_ld.pop_front();
          chk("load_val", 32'(cnt_load_val), 32'(l.val));
          chk("load_la_gnt", 32'(la_gnt), 32'(l.la));
          chk("cnt_en_in_load", 32'(cnt_en), 0);
        end
      end else if (la_gnt) begin
        chk("la_gnt_without_load", 32'(la_gnt), 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'hF; dat_i = '0; adr = '0;
    la_req = 1'b0; la_val = '0; cnt_value = 30'h55;
    tick();
    @(negedge clk);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_dat", dat_o, 0);
    chk("rst_cnt_load", 32'(cnt_load), 0);
    chk("rst_la_gnt", 32'(la_gnt), 0);
    chk("rst_cnt_en", 32'(cnt_en), 0);
    chk("rst_cnt_step", 32'(cnt_step), 0);
    chk("rst_irq", 32'(irq), 0);
    tick();
    rst = 1'b0;
    tick();

    // CTRL write/read; unused bits dropped
    wr(A_CTRL, 32'hA5A5_0101);
    @(negedge clk);
    chk("t1_step", 32'(cnt_step), 1);
    chk("t1_cnt_en", 32'(cnt_en), 1);
    rd(A_CTRL, 32'h0000_0101);

    // Host load, no contention
    push_ld(1'b0, 30'h100);
    wr(A_LOAD, 32'h100);
    rd(A_LOAD, 32'h100);
    rd(A_STAT, 32'h0000_5501);

    // Contention with last_gnt=WB: LA first, pending visible, then WB
    la_val = 30'h5;
    push_ld(1'b1, 30'h5);
    push_ld(1'b0, 30'h200);
    xfer(1'b1, A_LOAD, 32'h200, 4'hF, 0, 1'b1);
    la_req = 1'b0;
    rd(A_STAT, 32'h0000_5505);
    rd(A_STAT, 32'h0000_5501);

    // LA alone wins, leaving last_gnt=LA
    la_val = 30'h33;
    push_ld(1'b1, 30'h33);
    la_req = 1'b1;
    tick();
    la_req = 1'b0;

    // Contention with last_gnt=LA: WB first, LA next cycle
    la_val = 30'h5;
    push_ld(1'b0, 30'h7);
    push_ld(1'b1, 30'h5);
    xfer(1'b1, A_LOAD, 32'h7, 4'hF, 0, 1'b1);
    tick();
    la_req = 1'b0;
    rd(A_LOAD, 32'h7);

    // Byte strobes and bits above BITS
    xfer(1'b1, A_LIMIT, 32'hFFFF_FF22, 4'b0001, 0, 1'b0);
    rd(A_LIMIT, 32'h0000_0022);
    xfer(1'b1, A_LIMIT, 32'hFF00_0000, 4'b1000, 0, 1'b0);
    rd(A_LIMIT, 32'h3F00_0022);
    wr(A_LIMIT, 32'hFFFF_FFFF);
    rd(A_LIMIT, 32'h3FFF_FFFF);
    wr(A_LIMIT, 32'h10);

    // Oneshot limit hit -> HALT, irq, W1C
    cnt_value = 30'h0F;
    wr(A_CTRL, 32'h0B);
    cnt_value = 30'h10;
    tick();
    @(negedge clk);
    chk("t4_cnt_en", 32'(cnt_en), 0);
    chk("t4_irq", 32'(irq), 1);
    rd(A_STAT, 32'h0000_1002);
    wr(A_STAT, 32'h2);
    @(negedge clk);
    chk("t4_irq_clr", 32'(irq), 0);
    rd(A_STAT, 32'h0000_1000);

    // Load grant restarts a halted counter
    cnt_value = 30'h05;
    push_ld(1'b0, 30'h5);
    wr(A_LOAD, 32'h5);
    rd(A_STAT, 32'h0000_0501);

    // Free-running limit hit stays in RUN; set beats W1C; W1C honours byte strobe
    wr(A_CTRL, 32'h09);
    cnt_value = 30'h10;
    tick();
    @(negedge clk);
    chk("t5_cnt_en", 32'(cnt_en), 1);
    chk("t5_irq", 32'(irq), 1);
    rd(A_STAT, 32'h0000_1003);
    wr(A_STAT, 32'h2);
    rd(A_STAT, 32'h0000_1003);
    cnt_value = 30'h11;
    xfer(1'b1, A_STAT, 32'h2, 4'b1110, 0, 1'b0);
    rd(A_STAT, 32'h0000_1103);
    wr(A_STAT, 32'h2);
    rd(A_STAT, 32'h0000_1101);
    @(negedge clk);
    chk("t5_irq_clr", 32'(irq), 0);

    // Reset in the middle of an access with an LA request held
    cnt_value = 30'h10;
    tick();
    tick();
    la_val = 30'h2A; la_req = 1'b1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = A_LOAD; dat_i = 32'h99; sel = 4'hF;
    rst = 1'b1;
    tick();
    chk("t6_ack", 32'(ack), 0);
    chk("t6_cnt_load", 32'(cnt_load), 0);
    chk("t6_la_gnt", 32'(la_gnt), 0);
    chk("t6_cnt_en", 32'(cnt_en), 0);
    chk("t6_irq", 32'(irq), 0);
    chk("t6_dat", dat_o, 0);
    push_ld(1'b1, 30'h2A);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    chk("t6_first_gnt", 32'(la_gnt), 1);
    tick();
    la_req = 1'b0;
    @(negedge clk);
    chk("t6_no_ack", 32'(ack), 0);
    tick();

    // Address miss: acked, reads 0, writes dropped
    rd(BASE + 32'h10, 32'h0);
    wr(BASE + 32'h10, 32'hFFFF_FFFF);
    rd(A_CTRL, 32'h0);
    rd(A_STAT, 32'h0000_1000);

    repeat (3) tick();
    chk("acc_queue_empty", 32'(exp_acc.size()), 0);
    chk("load_queue_empty", 32'(exp_ld.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
